// File: rtl/vga_pixel_mixer.sv
// VGA colour stage: per-pixel layer select, writable palette lookup, 2-stage pipeline.
// Optional palette-index blinking is built when VGA_MIXER_BLINK_EN is defined.
module vga_pixel_mixer #(
  parameter int unsigned COLOR_BITS   = 10,
  parameter int unsigned IDX_BITS     = 2,
  parameter int unsigned SCORE_IDX    = 1,
  parameter int unsigned ROM_IDX      = 3,
  parameter int unsigned BG_IDX       = 0,
  parameter int unsigned BLINK_IDX    = 2,
  parameter int unsigned BLINK_FRAMES = 15
) (
  input  logic                      clock_25,
  input  logic                      reset,
  input  logic                      display_area,
  input  logic                      game_enable,
  input  logic [IDX_BITS-1:0]       color_data,
  input  logic                      score_time_enable,
  input  logic                      datarom,
  input  logic                      frame_start,
  input  logic                      blink_en,
  input  logic                      pal_wr_en,
  input  logic [IDX_BITS-1:0]       pal_wr_idx,
  input  logic [3*COLOR_BITS-1:0]   pal_wr_rgb,
  output logic [COLOR_BITS-1:0]     red,
  output logic [COLOR_BITS-1:0]     green,
  output logic [COLOR_BITS-1:0]     blue,
  output logic                      pix_valid
);

  localparam int unsigned DEPTH = 2**IDX_BITS;
  localparam int unsigned RGB_W = 3*COLOR_BITS;

  function automatic logic [RGB_W-1:0] pal_init(input int unsigned idx);
    logic [COLOR_BITS-1:0] lo;
    logic [COLOR_BITS-1:0] hi;
    lo = '0;
    hi = '1;
    case (idx)
      1:       pal_init = {lo, hi, lo};
      2:       pal_init = {hi, lo, lo};
      3:       pal_init = {hi, hi, hi};
      default: pal_init = '0;
    endcase
  endfunction

  logic [RGB_W-1:0]    r_pal [DEPTH];
  logic [IDX_BITS-1:0] r_sel_idx;
  logic                r_vis;
  logic [IDX_BITS-1:0] w_sel_idx;
  logic                w_hidden;
  logic [RGB_W-1:0]    w_rgb;

`ifdef VGA_MIXER_BLINK_EN
  localparam int unsigned CNT_W = $clog2(BLINK_FRAMES + 1);

  typedef enum logic {PH_VISIBLE, PH_HIDDEN} phase_t;

  phase_t           r_phase;
  phase_t           w_phase_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_phase <= PH_VISIBLE;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    if (!blink_en) begin
      w_phase_nxt = PH_VISIBLE;
      w_cnt_nxt   = '0;
    end else if (frame_start) begin
      if (r_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        w_cnt_nxt   = '0;
        w_phase_nxt = (r_phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // Gated by blink_en so dropping the enable shows the index in the same cycle.
  assign w_hidden = blink_en && (r_phase == PH_HIDDEN);
`else
  logic w_unused_blink;
  assign w_unused_blink = frame_start ^ blink_en;
  assign w_hidden       = 1'b0;
`endif

  always_comb begin
    w_sel_idx = IDX_BITS'(BG_IDX);
    if (game_enable) begin
      if (w_hidden && (color_data == IDX_BITS'(BLINK_IDX))) begin
        w_sel_idx = IDX_BITS'(BG_IDX);
      end else begin
        w_sel_idx = color_data;
      end
    end else if (score_time_enable) begin
      w_sel_idx = IDX_BITS'(SCORE_IDX);
    end else if (datarom) begin
      w_sel_idx = IDX_BITS'(ROM_IDX);
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_sel_idx <= '0;
      r_vis     <= 1'b0;
    end else begin
      r_sel_idx <= w_sel_idx;
      r_vis     <= display_area;
    end
  end

  // Non-blocking write: a lookup at the write edge still returns the old entry.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pal[i] <= pal_init(i);
      end
    end else if (pal_wr_en) begin
      r_pal[pal_wr_idx] <= pal_wr_rgb;
    end
  end

  assign w_rgb = r_vis ? r_pal[r_sel_idx] : '0;

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      pix_valid <= 1'b0;
    end else begin
      red       <= w_rgb[RGB_W-1 -: COLOR_BITS];
      green     <= w_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
      blue      <= w_rgb[COLOR_BITS-1:0];
      pix_valid <= r_vis;
    end
  end

endmodule
